// File: rtl/abs_diff_mon_pkg.sv
// abs_diff_mon_pkg: shared sweep states, width helpers and unsigned abs-difference
package abs_diff_mon_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;
  localparam int MAXW = 32;
  function automatic int vec_w(input int w);
    return 2 * w;
  endfunction
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int sum_w(input int w);
    return 3 * w;
  endfunction
  function automatic logic [MAXW-1:0] abs_sub(input logic [MAXW-1:0] x, input logic [MAXW-1:0] y);
    return (x > y) ? x - y : y - x;
  endfunction
endpackage

// File: rtl/abs_diff_ref.sv
// abs_diff_ref: exact |a-b| from a packed {b, a} vector; golden model for approximate netlists
module abs_diff_ref
  import abs_diff_mon_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [2*W-1:0] vec_i,
  output logic [W-1:0]   diff_o
);
  assign diff_o = W'(abs_sub(MAXW'(vec_i[W-1:0]), MAXW'(vec_i[2*W-1:W])));
endmodule

// File: rtl/abs_diff_error_monitor.sv
// abs_diff_error_monitor: exhaustive sweep of an approximate |a-b| netlist with error accounting.
// Define ABS_DIFF_MON_SUM_EN to add the err_sum_o total-error output.
module abs_diff_error_monitor
  import abs_diff_mon_pkg::*;
#(
  parameter int W  = 2,
  parameter int ET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic [vec_w(W)-1:0]   dut_in_o,
  input  logic [W-1:0]          dut_out_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [W-1:0]          err_max_o,
  output logic [cnt_w(W)-1:0]   viol_cnt_o,
`ifdef ABS_DIFF_MON_SUM_EN
  output logic [sum_w(W)-1:0]   err_sum_o,
`endif
  output logic                  pass_o
);
  localparam int VW = vec_w(W);
  localparam int CW = cnt_w(W);
  state_e st_q, st_d;
  logic [VW-1:0] vec_q, vec_d, s1_vec_q, s1_vec_d;
  logic [W-1:0] s1_out_q, s1_out_d, emax_q, emax_d, exact, err;
  logic [CW-1:0] viol_q, viol_d;
  logic s1_vld_q, s1_vld_d, go, last;
  abs_diff_ref #(.W(W)) u_ref (.vec_i(s1_vec_q), .diff_o(exact));
  assign err  = W'(abs_sub(MAXW'(exact), MAXW'(s1_out_q)));
  assign go   = start_i && (st_q == IDLE || st_q == DONE);
  assign last = vec_q == '1;
  always_comb begin
    st_d     = go ? SWEEP : (st_q == DRAIN) ? DONE : st_q;
    vec_d    = go ? '0 : vec_q;
    s1_vld_d = 1'b0;
    s1_vec_d = s1_vec_q;
    s1_out_d = s1_out_q;
    if (st_q == SWEEP) begin
      s1_vld_d = 1'b1;
      s1_vec_d = vec_q;
      s1_out_d = dut_out_i;
      st_d     = last ? DRAIN : SWEEP;
      vec_d    = last ? vec_q : vec_q + VW'(1);
    end
    emax_d = go ? '0 : (s1_vld_q && err > emax_q) ? err : emax_q;
    viol_d = go ? '0 : viol_q + CW'(s1_vld_q && int'(err) > ET);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      vec_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_vec_q <= '0;
      s1_out_q <= '0;
      emax_q   <= '0;
      viol_q   <= '0;
    end else begin
      st_q     <= st_d;
      vec_q    <= vec_d;
      s1_vld_q <= s1_vld_d;
      s1_vec_q <= s1_vec_d;
      s1_out_q <= s1_out_d;
      emax_q   <= emax_d;
      viol_q   <= viol_d;
    end
  end
`ifdef ABS_DIFF_MON_SUM_EN
  localparam int SW = sum_w(W);
  logic [SW-1:0] sum_q, sum_d;
  always_comb sum_d = go ? '0 : s1_vld_q ? sum_q + SW'(err) : sum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
  assign err_sum_o = sum_q;
`endif
  assign dut_in_o   = vec_q;
  assign busy_o     = st_q == SWEEP || st_q == DRAIN;
  assign done_o     = st_q == DONE;
  assign err_max_o  = emax_q;
  assign viol_cnt_o = viol_q;
  assign pass_o     = viol_q == '0;
endmodule

// File: tb/tb_abs_diff_error_monitor.sv
// tb_abs_diff_error_monitor: two monitors (ET=0, ET=1) sweeping a shared behavioural netlist model
module tb_abs_diff_error_monitor;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2*W-1:0] din0, din1;
  logic [W-1:0] dout0, dout1, emax0, emax1;
  logic [2*W:0] viol0, viol1;
  logic busy0, busy1, done0, done1, pass0, pass1;
`ifdef ABS_DIFF_MON_SUM_EN
  logic [3*W-1:0] sum0, sum1;
`endif
  int mode = 0;
  int errors = 0, checks = 0;
  typedef struct {int emax; int v0; int v1; int sum;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // mode 0: exact, 1: stuck-at-zero, 2: exact except vector 5 reads 3
  function automatic int model(input int m, input int v);
    int a, b, e;
    a = v % 4;
    b = v / 4;
    e = (a > b) ? a - b : b - a;
    if (m == 1) return 0;
    if (m == 2 && v == 5) return 3;
    return e;
  endfunction

  always_comb dout0 = W'(model(mode, int'(din0)));
  always_comb dout1 = W'(model(mode, int'(din1)));

  abs_diff_error_monitor #(.W(W), .ET(0)) u0 (
    .clk(clk), .rst(rst), .start_i(start), .dut_in_o(din0), .dut_out_i(dout0),
    .busy_o(busy0), .done_o(done0), .err_max_o(emax0), .viol_cnt_o(viol0),
`ifdef ABS_DIFF_MON_SUM_EN
    .err_sum_o(sum0),
`endif
    .pass_o(pass0));

  abs_diff_error_monitor #(.W(W), .ET(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .dut_in_o(din1), .dut_out_i(dout1),
    .busy_o(busy1), .done_o(done1), .err_max_o(emax1), .viol_cnt_o(viol1),
`ifdef ABS_DIFF_MON_SUM_EN
    .err_sum_o(sum1),
`endif
    .pass_o(pass1));

  task automatic push_expected(input int m);
    exp_t x;
    x = '{0, 0, 0, 0};
    for (int v = 0; v < 16; v++) begin
      int a, b, e, r;
      a = v % 4;
      b = v / 4;
      e = (a > b) ? a - b : b - a;
      r = model(m, v);
      r = (r > e) ? r - e : e - r;
      if (r > x.emax) x.emax = r;
      if (r > 0) x.v0++;
      if (r > 1) x.v1++;
      x.sum += r;
    end
    sb.push_back(x);
  endtask

  task automatic run_sweep(input string name, input bit pulse_mid);
    int edges, busy_n;
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    busy_n = busy0 ? 1 : 0;
    while (!done0 && edges < 100) begin
      start = pulse_mid && (edges == 5);
      @(posedge clk); #1;
      edges++;
      if (busy0) busy_n++;
    end
    start = 1'b0;
    checks++;
    if (edges != 17 || !done1) begin
      errors++;
      $display("FAIL %s latency: edges=%0d done1=%b, required 17 and 1", name, edges, done1);
    end
    checks++;
    if (busy_n != 17) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, required 17", name, busy_n);
    end
    x = sb.pop_front();
    checks++;
    if (int'(emax0) != x.emax || int'(emax1) != x.emax) begin
      errors++;
      $display("FAIL %s err_max: got %0d/%0d, required %0d", name, emax0, emax1, x.emax);
    end
    checks++;
    if (int'(viol0) != x.v0) begin
      errors++;
      $display("FAIL %s viol_cnt_et0: got %0d, required %0d", name, viol0, x.v0);
    end
    checks++;
    if (int'(viol1) != x.v1) begin
      errors++;
      $display("FAIL %s viol_cnt_et1: got %0d, required %0d", name, viol1, x.v1);
    end
    checks++;
    if (pass0 !== (x.v0 == 0) || pass1 !== (x.v1 == 0)) begin
      errors++;
      $display("FAIL %s pass: got %b/%b, required %b/%b", name, pass0, pass1, x.v0 == 0, x.v1 == 0);
    end
`ifdef ABS_DIFF_MON_SUM_EN
    checks++;
    if (int'(sum0) != x.sum || int'(sum1) != x.sum) begin
      errors++;
      $display("FAIL %s err_sum: got %0d/%0d, required %0d", name, sum0, sum1, x.sum);
    end
`endif
    @(negedge clk);
    checks++;
    if (!done0 || din0 !== 4'hf) begin
      errors++;
      $display("FAIL %s done_hold: done=%b dut_in=%h, required 1 and f", name, done0, din0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({din0, busy0, done0, emax0, viol0, pass0} !== 14'b0000_0_0_00_00000_1 ||
        {din1, busy1, done1, emax1, viol1, pass1} !== 14'b0000_0_0_00_00000_1) begin
      errors++;
      $display("FAIL reset_state: got %b/%b, required 00000000000001",
               {din0, busy0, done0, emax0, viol0, pass0}, {din1, busy1, done1, emax1, viol1, pass1});
    end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    mode = 0;
    push_expected(0);
    run_sweep("exact", 1'b0);
  endtask

  task automatic test_start_ignored();
    mode = 1;
    push_expected(1);
    run_sweep("stuck_zero_start_pulse", 1'b1);
  endtask

  task automatic test_restart_from_done();
    mode = 2;
    push_expected(2);
    run_sweep("single_fault_restart", 1'b0);
  endtask

  task automatic test_reset_mid();
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (!busy0 || din0 !== 4'd7) begin
      errors++;
      $display("FAIL mid_sweep_progress: busy=%b dut_in=%0d, required 1 and 7", busy0, din0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({din0, busy0, done0, emax0, viol0, pass0} !== 14'b0000_0_0_00_00000_1) begin
      errors++;
      $display("FAIL async_reset: got %b, required 00000000000001", {din0, busy0, done0, emax0, viol0, pass0});
    end
    @(negedge clk);
    rst = 1'b0;
    push_expected(1);
    run_sweep("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_start_ignored();
    test_restart_from_done();
    test_reset_mid();
    mode = 0;
    push_expected(0);
    run_sweep("back_to_back", 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
